// File: rtl/lfsr_dice_roller_if.sv
// rtl/lfsr_dice_roller_if.sv - control/result bundle for the LFSR dice roller (FORCE_ROLL_EN adds force ports)
interface lfsr_dice_roller_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_DICE = 2
);
    localparam int SUM_W = $clog2(6 * NUM_DICE + 1);

    logic                    clock_en;
    logic                    seed_load;
    logic [WIDTH-1:0]        seed;
    logic                    roll_req;
    logic                    roll_busy;
    logic                    roll_valid;
    logic [3*NUM_DICE-1:0]   dice;
    logic [SUM_W-1:0]        sum;
    logic [WIDTH-1:0]        lfsr_state;
`ifdef FORCE_ROLL_EN
    logic                    force_en;
    logic [3*NUM_DICE-1:0]   force_dice;
`endif

    // Controller side: drives requests and seed, observes results.
    modport master (
        output clock_en, seed_load, seed, roll_req,
`ifdef FORCE_ROLL_EN
        output force_en, force_dice,
`endif
        input  roll_busy, roll_valid, dice, sum, lfsr_state
    );

    // Roller side.
    modport slave (
        input  clock_en, seed_load, seed, roll_req,
`ifdef FORCE_ROLL_EN
        input  force_en, force_dice,
`endif
        output roll_busy, roll_valid, dice, sum, lfsr_state
    );
endinterface

// File: rtl/lfsr_dice_roller.sv
// rtl/lfsr_dice_roller.sv - Fibonacci LFSR with spin/extract roll controller (optional FORCE_ROLL_EN)
module lfsr_dice_roller #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] TAPS        = 16'hB400,
    parameter logic [WIDTH-1:0] RESET_SEED  = 1,
    parameter int               NUM_DICE    = 2,
    parameter int               SPIN_CYCLES = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    lfsr_dice_roller_if.slave bus
);
    localparam int SUM_W = $clog2(6 * NUM_DICE + 1);
    localparam int IDX_W = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
    localparam int CNT_W = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPIN    = 2'd1,
        EXTRACT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state;
    logic [WIDTH-1:0]        lfsr;
    logic [CNT_W-1:0]        spin_cnt;
    logic [IDX_W-1:0]        die_idx;
    logic [3*NUM_DICE-1:0]   shadow;
    logic [3*NUM_DICE-1:0]   dice_q;
    logic [SUM_W-1:0]        sum_q;
    logic                    valid_q;
    logic                    busy_q;
`ifdef FORCE_ROLL_EN
    logic                    force_q;
`endif

    logic [WIDTH-1:0]        lfsr_step;
    logic [WIDTH-1:0]        seed_fixed;
    logic [2:0]              candidate;
    logic                    cand_ok;
    logic                    last_die;
    logic [3*NUM_DICE-1:0]   shadow_next;

    function automatic logic [SUM_W-1:0] dice_sum(input logic [3*NUM_DICE-1:0] d);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            acc = acc + SUM_W'(d[3*i +: 3]);
        end
        return acc;
    endfunction

    assign lfsr_step  = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    // An all-zero seed would lock the LFSR forever, so it is replaced by 1.
    assign seed_fixed = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
    assign candidate  = lfsr[2:0];
    assign cand_ok    = (candidate != 3'd0) && (candidate != 3'd7);
    assign last_die   = (die_idx == IDX_W'(NUM_DICE - 1));

    // Shadow dice with the current candidate merged in at the active index.
    always_comb begin
        shadow_next = shadow;
        shadow_next[3*int'(die_idx) +: 3] = candidate;
    end

    // LFSR, roll FSM and registered outputs; clock_en low freezes everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lfsr     <= RESET_SEED;
            spin_cnt <= '0;
            die_idx  <= '0;
            shadow   <= '0;
            dice_q   <= '0;
            sum_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FORCE_ROLL_EN
            force_q  <= 1'b0;
`endif
        end else if (bus.clock_en) begin
            valid_q <= 1'b0;
            if (bus.seed_load) begin
                // Reseeding abandons any roll in flight; outputs keep the last roll.
                lfsr   <= seed_fixed;
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                lfsr <= lfsr_step;
                case (state)
                    IDLE: begin
                        if (bus.roll_req) begin
                            state    <= SPIN;
                            spin_cnt <= CNT_W'(SPIN_CYCLES - 1);
                            die_idx  <= '0;
                            busy_q   <= 1'b1;
`ifdef FORCE_ROLL_EN
                            force_q  <= bus.force_en;
`endif
                        end
                    end
                    SPIN: begin
                        if (spin_cnt == '0) begin
`ifdef FORCE_ROLL_EN
                            if (force_q) begin
                                state   <= DONE;
                                dice_q  <= bus.force_dice;
                                sum_q   <= dice_sum(bus.force_dice);
                                valid_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state <= EXTRACT;
                            end
`else
                            state <= EXTRACT;
`endif
                        end else begin
                            spin_cnt <= spin_cnt - CNT_W'(1);
                        end
                    end
                    EXTRACT: begin
                        if (cand_ok) begin
                            shadow  <= shadow_next;
                            die_idx <= die_idx + IDX_W'(1);
                            if (last_die) begin
                                state   <= DONE;
                                dice_q  <= shadow_next;
                                sum_q   <= dice_sum(shadow_next);
                                valid_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.lfsr_state = lfsr;
    assign bus.dice       = dice_q;
    assign bus.sum        = sum_q;
    assign bus.roll_valid = valid_q;
    assign bus.roll_busy  = busy_q;
endmodule

// File: tb/tb_lfsr_dice_roller.sv
// tb/tb_lfsr_dice_roller.sv - randomized self-checking bench for lfsr_dice_roller (FORCE_ROLL_EN cases when defined)
module tb_lfsr_dice_roller;
    localparam int          SPIN   = 8;
    localparam int          NDICE  = 2;
    localparam logic [15:0] TAPS_M = 16'hB400;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;
    logic [15:0] m_state;

    lfsr_dice_roller_if #(.WIDTH(16), .NUM_DICE(NDICE)) bus ();

    lfsr_dice_roller #(
        .WIDTH(16), .TAPS(TAPS_M), .RESET_SEED(16'd1),
        .NUM_DICE(NDICE), .SPIN_CYCLES(SPIN)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference step: shift left by one, feedback is the parity of the tapped bits.
    function automatic logic [15:0] nxt(input logic [15:0] s);
        int fb;
        fb = $countones(s & TAPS_M) % 2;
        return 16'((32'(s) * 2 + fb) % 65536);
    endfunction

    task automatic tick(input logic en, input logic ld, input logic [15:0] sd, input logic rq);
        bus.clock_en  = en;
        bus.seed_load = ld;
        bus.seed      = sd;
        bus.roll_req  = rq;
        @(posedge clock);
        if (en) m_state = ld ? ((sd == 16'd0) ? 16'd1 : sd) : nxt(m_state);
        #1;
    endtask

    task automatic do_roll(input int gate_len, input bit force_it, input logic [5:0] fdice);
        logic [15:0] t;
        logic [15:0] snap;
        logic [5:0]  exp_dice;
        logic [5:0]  old_dice;
        int          ncand, nd, exp_lat, exp_sum, lat, tot;
        bit          gated;
        t = nxt(m_state);
        repeat (SPIN) t = nxt(t);
        ncand = 0;
        nd = 0;
        exp_dice = 6'd0;
        if (force_it) begin
            exp_dice = fdice;
            exp_lat  = SPIN + 1;
        end else begin
            while (nd < NDICE) begin
                int c;
                c = int'(t % 8);
                t = nxt(t);
                ncand++;
                if (c >= 1 && c <= 6) begin
                    exp_dice[3*nd +: 3] = 3'(c);
                    nd++;
                end
            end
            exp_lat = SPIN + 1 + ncand;
        end
        exp_sum  = int'(exp_dice[2:0]) + int'(exp_dice[5:3]);
        old_dice = bus.dice;
`ifdef FORCE_ROLL_EN
        bus.force_en   = force_it;
        bus.force_dice = fdice;
`endif
        tick(1, 0, 16'd0, 1);
        lat = 1;
        tot = 1;
        gated = 0;
        while (!bus.roll_valid && lat < 300) begin
            check("busy_mid_roll", 32'(bus.roll_busy), 32'd1);
            check("dice_hold_mid_roll", 32'(bus.dice), 32'(old_dice));
            if (gate_len > 0 && !gated && lat == SPIN + 1) begin
                snap = bus.lfsr_state;
                repeat (gate_len) begin
                    tick(0, 0, 16'd0, 0);
                    tot++;
                    check("gate_lfsr_frozen", 32'(bus.lfsr_state), 32'(snap));
                    check("gate_busy_frozen", 32'(bus.roll_busy), 32'd1);
                    check("gate_no_valid", 32'(bus.roll_valid), 32'd0);
                end
                gated = 1;
            end
            tick(1, 0, 16'd0, 0);
            lat++;
            tot++;
        end
        check("roll_latency", 32'(lat), 32'(exp_lat));
        check("roll_total_cycles", 32'(tot), 32'(exp_lat + gate_len));
        check("roll_valid_high", 32'(bus.roll_valid), 32'd1);
        check("roll_busy_done", 32'(bus.roll_busy), 32'd0);
        check("roll_dice", 32'(bus.dice), 32'(exp_dice));
        check("roll_sum", 32'(bus.sum), 32'(exp_sum));
        check("roll_lfsr", 32'(bus.lfsr_state), 32'(m_state));
        if (!force_it) begin
            for (int i = 0; i < NDICE; i++) begin
                logic [5:0] dv;
                dv = bus.dice;
                check("die_in_range", 32'((dv[3*i +: 3] >= 3'd1) && (dv[3*i +: 3] <= 3'd6)), 32'd1);
            end
        end
        tick(1, 0, 16'd0, 0);
        check("valid_one_cycle", 32'(bus.roll_valid), 32'd0);
        check("dice_after_done", 32'(bus.dice), 32'(exp_dice));
        check("sum_after_done", 32'(bus.sum), 32'(exp_sum));
        check("busy_after_done", 32'(bus.roll_busy), 32'd0);
`ifdef FORCE_ROLL_EN
        bus.force_en = 1'b0;
`endif
    endtask

    initial begin
        int          first, err;
        logic [15:0] sd;
        logic [5:0]  old_dice;
        logic [3:0]  old_sum;
        int          vcount;
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        bus.clock_en = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed = 16'd0;
        bus.roll_req = 1'b0;
`ifdef FORCE_ROLL_EN
        bus.force_en = 1'b0;
        bus.force_dice = 6'd0;
`endif
        m_state = 16'd1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_lfsr", 32'(bus.lfsr_state), 32'h0001);
        check("reset_dice", 32'(bus.dice), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_valid", 32'(bus.roll_valid), 32'd0);
        check("reset_busy", 32'(bus.roll_busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;

        // Zero seed is promoted to 1, then the full period is walked.
        tick(1, 1, 16'h0000, 0);
        check("seed_zero_guard", 32'(bus.lfsr_state), 32'h0001);
        first = 0;
        err = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick(1, 0, 16'd0, 0);
            if (bus.lfsr_state == 16'h0001 && first == 0) first = i;
            if (bus.lfsr_state != m_state) err++;
        end
        check("period_first_return", 32'(first), 32'd65535);
        check("period_track", 32'(err), 32'd0);

        // Reference roll and its clock-gated repeat from the same seed.
        tick(1, 1, 16'hACE1, 0);
        check("seed_load_acel", 32'(bus.lfsr_state), 32'hACE1);
        do_roll(0, 0, 6'd0);
        tick(1, 1, 16'hACE1, 0);
        do_roll(5, 0, 6'd0);

        // Random seeds, press timing and gating.
        for (int r = 0; r < 10; r++) begin
            sd = 16'($urandom);
            tick(1, 1, sd, 0);
            repeat ($urandom_range(0, 20)) tick(1'($urandom_range(0, 1)), 0, 16'd0, 0);
            do_roll(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0, 0, 6'd0);
        end

        // Seed load during SPIN aborts the roll.
        old_dice = bus.dice;
        old_sum  = bus.sum;
        tick(1, 0, 16'd0, 1);
        repeat (3) tick(1, 0, 16'd0, 0);
        check("abort_busy_before", 32'(bus.roll_busy), 32'd1);
        tick(1, 1, 16'h1234, 0);
        check("abort_busy", 32'(bus.roll_busy), 32'd0);
        check("abort_seed", 32'(bus.lfsr_state), 32'h1234);
        vcount = 0;
        repeat (15) begin
            tick(1, 0, 16'd0, 0);
            vcount += int'(bus.roll_valid) + int'(bus.roll_busy);
        end
        check("abort_no_valid", 32'(vcount), 32'd0);
        check("abort_dice_kept", 32'(bus.dice), 32'(old_dice));
        check("abort_sum_kept", 32'(bus.sum), 32'(old_sum));
        check("abort_lfsr", 32'(bus.lfsr_state), 32'(m_state));

`ifdef FORCE_ROLL_EN
        do_roll(0, 1, 6'b110_101);
`endif

        // Asynchronous reset mid-roll, checked between clock edges.
        tick(1, 0, 16'd0, 1);
        repeat (4) tick(1, 0, 16'd0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_lfsr", 32'(bus.lfsr_state), 32'h0001);
        check("async_reset_dice", 32'(bus.dice), 32'd0);
        check("async_reset_sum", 32'(bus.sum), 32'd0);
        check("async_reset_valid", 32'(bus.roll_valid), 32'd0);
        check("async_reset_busy", 32'(bus.roll_busy), 32'd0);
        m_state = 16'd1;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        tick(1, 1, 16'hBEEF, 0);
        do_roll(0, 0, 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lfsr_dice_roller.md
Name: lfsr_dice_roller

Overview:
- Parametrised Fibonacci LFSR with a roll controller for the craps datapath.
- LFSR free-runs on clock_en; user press timing provides the entropy.
- On a roll request: spins a fixed number of steps, then fills NUM_DICE dice with values 1..6 by rejection sampling.
- Presents dice and sum with a valid pulse; sits between the button/controller FSM and the score/compare logic.

Parameters:
- WIDTH, 16: LFSR width in bits, must be >= 4.
- TAPS, 16'hB400: feedback tap mask; bit k set means state[k] is XORed into feedback.
- RESET_SEED, 1: LFSR value on reset; must be nonzero.
- NUM_DICE, 2: number of dice per roll, 1..4.
- SPIN_CYCLES, 8: LFSR advances between roll acceptance and first extraction, must be >= 1.
- Derived SUM_W = $clog2(6*NUM_DICE+1).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- clock_en  in  1  advance enable; low freezes LFSR and FSM completely.
- seed_load  in  1  load seed into LFSR this cycle.
- seed  in  WIDTH  seed value.
- roll_req  in  1  request a roll (level, sampled in IDLE).
- roll_busy  out  1  high in SPIN/EXTRACT.
- roll_valid  out  1  one-cycle pulse when dice/sum update.
- dice  out  3*NUM_DICE  die i in bits [3i+2:3i], each 1..6.
- sum  out  SUM_W  sum of all dice.
- lfsr_state  out  WIDTH  current LFSR value.

Behaviour:
Reset (reset_n low, asynchronous):
- lfsr_state=RESET_SEED, FSM=IDLE.
- dice=0, sum=0, roll_valid=0, roll_busy=0.

LFSR step, every clock_en cycle:
- next = {state[WIDTH-2:0], ^(state & TAPS)}.

Seed load (seed_load & clock_en):
- Loads seed, or 1 if seed==0 (zero-lock guard); no step that cycle.
- Has priority over stepping.
- If FSM is not IDLE: abort to IDLE, no roll_valid, dice/sum keep old values.

FSM (all transitions only on clock_en cycles):
- IDLE: roll_req=1 -> SPIN, spin counter=SPIN_CYCLES-1, die index=0.
- SPIN: counter decrements each step; at 0 -> EXTRACT.
- EXTRACT: each cycle, candidate c=state[2:0] (pre-step value).
  - If 1<=c<=6: write die[index]=c, index++.
  - Else (0 or 7): reject, index unchanged.
  - LFSR steps every cycle regardless.
  - When the last die is written -> DONE.
- DONE: roll_valid=1 for exactly this cycle; sum valid this cycle; -> IDLE. roll_req sampled only in IDLE, so back-to-back rolls need roll_req still high in the next IDLE cycle.

Outputs and timing:
- dice and sum are registered; they change only on the cycle roll_valid rises and hold until the next completed roll.
- Intermediate dice updates are kept internal (shadow register), committed to outputs in DONE.
- roll_busy is high in SPIN and EXTRACT, low in IDLE and DONE.
- Minimum latency, roll_req high in IDLE to roll_valid: SPIN_CYCLES + NUM_DICE + 1 enabled cycles, plus 1 per rejected candidate.
- roll_req while busy is ignored (no queuing).
- clock_en low mid-roll: state held exactly, resumes on re-enable.

Optional Feature:
Macro FORCE_ROLL_EN.
- Defined: adds ports force_en (in, 1) and force_dice (in, 3*NUM_DICE).
  - If force_en=1 when a roll is accepted in IDLE: SPIN still runs; EXTRACT is skipped; DONE commits force_dice and its sum.
  - Latency SPIN_CYCLES+1; LFSR still steps during SPIN.
  - Force values outside 1..6 are committed unchanged (test use only).
- Undefined: ports absent; behaviour as above.

Test Plan:
- Reset: assert reset_n=0 mid-roll -> dice=0, sum=0, roll_valid=0, roll_busy=0, lfsr_state=16'h0001 immediately, without waiting for a clock edge.
- Seed 0: seed_load=1, seed=16'h0000 -> lfsr_state=16'h0001 next edge; then 65535 enabled steps return to 16'h0001 with no earlier repeat (maximal length for default TAPS).
- Roll, defaults: seed 16'hACE1, single roll_req pulse -> roll_busy 8+ cycles; roll_valid once; each die 1..6; sum = die0+die1; dice match the bench LFSR model including rejections; latency = 11 + rejections.
- clock_en gating: drop clock_en for 5 cycles during EXTRACT -> lfsr_state, dice, busy frozen; roll_valid arrives exactly 5 cycles later than the ungated run.
- Abort: seed_load during SPIN -> FSM IDLE, roll_busy=0, no roll_valid, dice/sum unchanged from prior roll.
- FORCE_ROLL_EN build: force_en=1, force_dice=6'b110_101 -> roll_valid after 9 cycles, dice={6,5}, sum=11.
